// File: rtl/read_ptr_empty_ctrl_if.sv
// Read-side bus of the async FIFO read pointer/empty controller.
// Carries underflow_cnt only when READ_UNDERFLOW_CNT_EN is defined.
interface read_ptr_empty_ctrl_if #(
  parameter int FIFO_DEPTH_BIT = 4,
  parameter int SEL_W          = 1
);
  logic                    r_en;
  logic [FIFO_DEPTH_BIT:0] write_addr_gray;
  logic                    flag_empty;
  logic                    flag_almost_empty;
  logic [FIFO_DEPTH_BIT-1:0] read_addr;
  logic [FIFO_DEPTH_BIT:0] read_addr_gray;
  logic [SEL_W-1:0]        read_sel;
  logic [FIFO_DEPTH_BIT:0] read_level;
  logic                    r_underflow;
`ifdef READ_UNDERFLOW_CNT_EN
  logic [7:0]              underflow_cnt;
`endif

  modport master (
    output r_en,
    output write_addr_gray,
    input  flag_empty,
    input  flag_almost_empty,
    input  read_addr,
    input  read_addr_gray,
    input  read_sel,
    input  read_level,
`ifdef READ_UNDERFLOW_CNT_EN
    input  underflow_cnt,
`endif
    input  r_underflow
  );

  modport slave (
    input  r_en,
    input  write_addr_gray,
    output flag_empty,
    output flag_almost_empty,
    output read_addr,
    output read_addr_gray,
    output read_sel,
    output read_level,
`ifdef READ_UNDERFLOW_CNT_EN
    output underflow_cnt,
`endif
    output r_underflow
  );
endinterface

// File: rtl/read_ptr_empty_ctrl.sv
// Async FIFO read pointer / empty controller with write-pointer CDC.
// Optional saturating underflow counter: define READ_UNDERFLOW_CNT_EN.
module read_ptr_empty_ctrl #(
  parameter int DATAIN_WIDTH    = 16,
  parameter int DATAOUT_WIDTH   = 32,
  parameter int FIFO_DEPTH_BIT  = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input logic r_clk,
  input logic r_rst,
  read_ptr_empty_ctrl_if.slave bus
);
  localparam int AW  = FIFO_DEPTH_BIT + 1;
  localparam int MUL = (DATAOUT_WIDTH >= DATAIN_WIDTH) ?
                       DATAOUT_WIDTH / DATAIN_WIDTH : 1;
  localparam int DIV = (DATAIN_WIDTH > DATAOUT_WIDTH) ?
                       DATAIN_WIDTH / DATAOUT_WIDTH : 1;
  localparam int SEL_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  logic [AW-1:0]    sync_q [SYNC_STAGES];
  logic [AW-1:0]    wr_bin_s;
  logic [AW-1:0]    rd_bin;
  logic [AW-1:0]    rd_nxt;
  logic [AW-1:0]    rd_gray;
  logic [AW-1:0]    level;
  logic [SEL_W-1:0] sub_cnt;
  logic [SEL_W-1:0] sub_nxt;
  logic             empty;
  logic             accept;
  logic             refuse;
  logic             uflow;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.write_addr_gray;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    wr_bin_s = '0;
    wr_bin_s[AW-1] = sync_q[SYNC_STAGES-1][AW-1];
    for (int i = AW - 2; i >= 0; i--)
      wr_bin_s[i] = wr_bin_s[i+1] ^ sync_q[SYNC_STAGES-1][i];
  end

  assign level  = wr_bin_s - rd_bin;
  assign empty  = (MUL > 1) ? (level < AW'(MUL)) : (level == '0);
  assign accept = bus.r_en && !empty;
  assign refuse = bus.r_en && empty;

  // Downsize walks the sub-word slices before moving to the next RAM word.
  always_comb begin
    rd_nxt  = rd_bin;
    sub_nxt = sub_cnt;
    if (accept) begin
      if (DIV > 1) begin
        if (sub_cnt == SEL_W'(DIV - 1)) begin
          sub_nxt = '0;
          rd_nxt  = rd_bin + AW'(1);
        end else begin
          sub_nxt = sub_cnt + SEL_W'(1);
        end
      end else begin
        rd_nxt = rd_bin + AW'(MUL);
      end
    end
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rd_bin  <= '0;
      rd_gray <= '0;
      sub_cnt <= '0;
      uflow   <= 1'b0;
    end else begin
      rd_bin  <= rd_nxt;
      rd_gray <= rd_nxt ^ (rd_nxt >> 1);
      sub_cnt <= sub_nxt;
      uflow   <= uflow | refuse;
    end
  end

`ifdef READ_UNDERFLOW_CNT_EN
  logic [7:0] ucnt;

  always_ff @(posedge r_clk) begin
    if (r_rst)
      ucnt <= '0;
    else if (refuse && ucnt != 8'hFF)
      ucnt <= ucnt + 8'd1;
  end

  assign bus.underflow_cnt = ucnt;
`endif

  assign bus.flag_empty        = empty;
  assign bus.flag_almost_empty = level <= AW'(ALMOST_EMPTY_TH);
  assign bus.read_addr         = rd_bin[FIFO_DEPTH_BIT-1:0];
  assign bus.read_addr_gray    = rd_gray;
  assign bus.read_sel          = (DIV > 1) ? sub_cnt : '0;
  assign bus.read_level        = level;
  assign bus.r_underflow       = uflow;
endmodule
